// File: rtl/wb_bram_pipe_interface_pkg.sv
// Shared types for the pipelined Wishbone-to-BRAM front-end: response kinds,
// the delay-line stage record and the stage-0 constructor.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_kind_t;

  typedef struct packed {
    rsp_kind_t kind;
    logic      is_read;
  } rsp_stage_t;

  localparam rsp_stage_t STAGE_IDLE = '{kind: RSP_NONE, is_read: 1'b0};

  function automatic rsp_stage_t make_stage(input logic accept, input logic in_range,
                                            input logic we);
    rsp_stage_t s;
    s = STAGE_IDLE;
    if (accept) begin
      s.kind    = in_range ? RSP_ACK : RSP_ERR;
      s.is_read = ~we;
    end else begin
      s = STAGE_IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/wb_bram_pipe_interface_if.sv
// Wishbone B4 pipelined bus bundle; signal names are from the slave's point of view.
interface wb_bram_pipe_interface_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_we_i;
  logic [SEL_WIDTH-1:0]  wb_sel_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

endinterface

// File: rtl/wb_bram_pipe_interface_delay.sv
// Response delay line: DEPTH registered stages carrying ACK/ERR/NONE in accept order.
// A flush (cycle abort) or reset empties every stage at the next edge.
module rsp_delay_line
  import wb_bram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  rsp_stage_t stage_i,
  output rsp_stage_t stage_o
);

  rsp_stage_t r_stages [DEPTH];

  // shift register of pending responses
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_stages[i] <= STAGE_IDLE;
    end else begin
      r_stages[0] <= stage_i;
      for (int i = 1; i < DEPTH; i++) r_stages[i] <= r_stages[i-1];
    end
  end

  assign stage_o = r_stages[DEPTH-1];

endmodule

// File: rtl/wb_bram_pipe_interface.sv
// Pipelined Wishbone B4 slave front-end for a BRAM: one request per cycle, memory strobes
// issued the same cycle, ACK/ERR returned MEM_LATENCY cycles later aligned with read data.
module wb_bram_pipe_interface
  import wb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_SIZE    = 4096,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wb_bram_pipe_interface_if.slave wb,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [DATA_WIDTH-1:0]   write_data_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  input  logic [DATA_WIDTH-1:0]   read_data_i
);

  localparam int LIMIT_W = ADDR_WIDTH + 1;
  // one extra bit so a memory covering the whole address space still compares correctly
  localparam logic [LIMIT_W-1:0] MEM_LIMIT = LIMIT_W'(MEM_SIZE);

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_in_range;
  rsp_stage_t            w_stage0;
  rsp_stage_t            w_last;
  logic                  w_ack;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdat;

  assign w_stall = rst_i;

  // request acceptance, range check and memory strobes
  always_comb begin
    w_accept   = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall;
    w_in_range = ({1'b0, wb.wb_adr_i} < MEM_LIMIT);
    read_o     = w_accept & w_in_range & ~wb.wb_we_i;
    write_o    = w_accept & w_in_range & wb.wb_we_i;
    w_stage0   = make_stage(w_accept, w_in_range, wb.wb_we_i);
  end

  rsp_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_rsp_delay_line (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~wb.wb_cyc_i),
    .stage_i (w_stage0),
    .stage_o (w_last)
  );

  // termination and read-data gating from the oldest pending response
  always_comb begin
    w_ack  = 1'b0;
    w_err  = 1'b0;
    w_rdat = '0;
    if (!rst_i && wb.wb_cyc_i) begin
      case (w_last.kind)
        RSP_ACK: begin
          w_ack = 1'b1;
          if (w_last.is_read) w_rdat = read_data_i;
          else                w_rdat = '0;
        end
        RSP_ERR: w_err = 1'b1;
        default: begin
          w_ack  = 1'b0;
          w_err  = 1'b0;
          w_rdat = '0;
        end
      endcase
    end else begin
      w_ack  = 1'b0;
      w_err  = 1'b0;
      w_rdat = '0;
    end
  end

  assign wb.wb_ack_o   = w_ack;
  assign wb.wb_err_o   = w_err;
  assign wb.wb_dat_o   = w_rdat;
  assign wb.wb_stall_o = w_stall;
  assign addr_o        = wb.wb_adr_i;
  assign write_data_o  = wb.wb_dat_i;
  assign sel_o         = wb.wb_sel_i;

endmodule

// File: tb/tb_wb_bram_pipe_interface.sv
// Directed bench: three instances (MEM_LATENCY 1, 2, 3) share one stimulus stream and a
// small byte-lane BRAM model whose read data is delayed per instance.
module tb_wb_bram_pipe_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  wb_bram_pipe_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  wb_bram_pipe_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  wb_bram_pipe_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus1.wb_cyc_i = cyc; assign bus1.wb_stb_i = stb; assign bus1.wb_we_i  = we;
  assign bus1.wb_adr_i = adr; assign bus1.wb_dat_i = wdat; assign bus1.wb_sel_i = sel;
  assign bus2.wb_cyc_i = cyc; assign bus2.wb_stb_i = stb; assign bus2.wb_we_i  = we;
  assign bus2.wb_adr_i = adr; assign bus2.wb_dat_i = wdat; assign bus2.wb_sel_i = sel;
  assign bus3.wb_cyc_i = cyc; assign bus3.wb_stb_i = stb; assign bus3.wb_we_i  = we;
  assign bus3.wb_adr_i = adr; assign bus3.wb_dat_i = wdat; assign bus3.wb_sel_i = sel;

  logic        ack [1:3];
  logic        err [1:3];
  logic        stall [1:3];
  logic        rd [1:3];
  logic        wr [1:3];
  logic [31:0] dat [1:3];
  logic [31:0] addr_w [1:3];
  logic [31:0] wdo_w [1:3];
  logic [3:0]  selo_w [1:3];
  logic [31:0] rdata [1:3];

  assign ack[1] = bus1.wb_ack_o; assign err[1] = bus1.wb_err_o;
  assign dat[1] = bus1.wb_dat_o; assign stall[1] = bus1.wb_stall_o;
  assign ack[2] = bus2.wb_ack_o; assign err[2] = bus2.wb_err_o;
  assign dat[2] = bus2.wb_dat_o; assign stall[2] = bus2.wb_stall_o;
  assign ack[3] = bus3.wb_ack_o; assign err[3] = bus3.wb_err_o;
  assign dat[3] = bus3.wb_dat_o; assign stall[3] = bus3.wb_stall_o;

  wb_bram_pipe_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(4096), .MEM_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb(bus1), .addr_o(addr_w[1]), .read_o(rd[1]), .write_o(wr[1]),
    .write_data_o(wdo_w[1]), .sel_o(selo_w[1]), .read_data_i(rdata[1]));
  wb_bram_pipe_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(4096), .MEM_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .wb(bus2), .addr_o(addr_w[2]), .read_o(rd[2]), .write_o(wr[2]),
    .write_data_o(wdo_w[2]), .sel_o(selo_w[2]), .read_data_i(rdata[2]));
  wb_bram_pipe_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(4096), .MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb(bus3), .addr_o(addr_w[3]), .read_o(rd[3]), .write_o(wr[3]),
    .write_data_o(wdo_w[3]), .sel_o(selo_w[3]), .read_data_i(rdata[3]));

  // BRAM model: preloaded on reset, byte-lane writes, read data delayed 1/2/3 cycles
  logic [31:0] mem [0:1023];
  logic [31:0] rd_cap, rd_d2, rd_d3;
  always @(posedge clk) begin
    if (rst) begin
      mem[1]    <= 32'h1234_5678;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[1023] <= 32'hCAFE_F00D;
    end else if (wr[1]) begin
      for (int b = 0; b < 4; b++)
        if (selo_w[1][b]) mem[addr_w[1][11:2]][8*b +: 8] <= wdo_w[1][8*b +: 8];
    end
    if (rd[1]) rd_cap <= mem[addr_w[1][11:2]];
    rd_d2 <= rd_cap;
    rd_d3 <= rd_d2;
  end
  assign rdata[1] = rd_cap;
  assign rdata[2] = rd_d2;
  assign rdata[3] = rd_d3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int l, input logic e_ack, input logic e_err,
                         input logic [31:0] e_dat);
    chk($sformatf("%s L%0d ack", tag, l), {31'd0, ack[l]}, {31'd0, e_ack});
    chk($sformatf("%s L%0d err", tag, l), {31'd0, err[l]}, {31'd0, e_err});
    chk($sformatf("%s L%0d dat", tag, l), dat[l], e_dat);
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl);
    cyc = c; stb = s; we = w; adr = a; wdat = d; sel = sl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    nxt();

    // reset held 3 cycles with cyc/stb high: stalled, no strobes, no responses
    for (int i = 0; i < 3; i++) begin
      we = (i == 1);
      @(negedge clk);
      for (int l = 1; l <= 3; l++) begin
        chk($sformatf("rst stall L%0d", l), {31'd0, stall[l]}, 32'd1);
        chk($sformatf("rst read_o L%0d", l), {31'd0, rd[l]}, 32'd0);
        chk($sformatf("rst write_o L%0d", l), {31'd0, wr[l]}, 32'd0);
        chk_rsp("rst", l, 1'b0, 1'b0, 32'h0);
      end
      nxt();
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      for (int l = 1; l <= 3; l++) begin
        chk($sformatf("post-rst stall L%0d", l), {31'd0, stall[l]}, 32'd0);
        chk_rsp("post-rst", l, 1'b0, 1'b0, 32'h0);
      end
      nxt();
    end

    // single read of 0x10 returning 0xDEADBEEF after each latency
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    for (int l = 1; l <= 3; l++) begin
      chk($sformatf("single read_o L%0d", l), {31'd0, rd[l]}, 32'd1);
      chk($sformatf("single addr_o L%0d", l), addr_w[l], 32'h10);
    end
    nxt();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int l = 1; l <= 3; l++)
        chk_rsp($sformatf("single t%0d", k), l, k == l, 1'b0, (k == l) ? 32'hDEAD_BEEF : 32'h0);
      nxt();
    end

    // back-to-back W 0x0, R 0x0, R 0x4
    for (int t = 0; t <= 6; t++) begin
      case (t)
        0:       drive(1'b1, 1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        2:       drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      endcase
      @(negedge clk);
      if (t == 0) begin
        chk("b2b write_o", {31'd0, wr[1]}, 32'd1);
        chk("b2b read_o on write", {31'd0, rd[1]}, 32'd0);
        chk("b2b write_data_o", wdo_w[2], 32'hA5A5_A5A5);
        chk("b2b sel_o", {28'd0, selo_w[3]}, 32'hF);
      end
      for (int l = 1; l <= 3; l++) begin
        chk($sformatf("b2b t%0d stall L%0d", t, l), {31'd0, stall[l]}, 32'd0);
        chk_rsp($sformatf("b2b t%0d", t), l, (t >= l) && (t <= l + 2), 1'b0,
                (t == l + 1) ? 32'hA5A5_A5A5 : (t == l + 2) ? 32'h1234_5678 : 32'h0);
      end
      nxt();
    end

    // range boundary: 0x1000 errors without a strobe, 0xFFC is in range
    for (int t = 0; t <= 5; t++) begin
      case (t)
        0:       drive(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      endcase
      @(negedge clk);
      if (t == 0) chk("range read_o 0x1000", {31'd0, rd[2]}, 32'd0);
      if (t == 1) chk("range read_o 0xFFC", {31'd0, rd[2]}, 32'd1);
      for (int l = 1; l <= 3; l++)
        chk_rsp($sformatf("range t%0d", t), l, t == l + 1, t == l,
                (t == l + 1) ? 32'hCAFE_F00D : 32'h0);
      nxt();
    end

    // abort: two reads, then cyc dropped (with stb high) for one cycle
    for (int t = 0; t <= 6; t++) begin
      case (t)
        0:       drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        2:       drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      endcase
      @(negedge clk);
      if (t == 2)
        for (int l = 1; l <= 3; l++) chk($sformatf("abort no-cyc read_o L%0d", l), {31'd0, rd[l]}, 32'd0);
      for (int l = 1; l <= 3; l++) begin
        chk($sformatf("abort t%0d L%0d ack", t, l), {31'd0, ack[l]}, {31'd0, (t == 1) && (l == 1)});
        chk($sformatf("abort t%0d L%0d err", t, l), {31'd0, err[l]}, 32'd0);
      end
      if (t == 1) chk("abort t1 L1 dat", dat[1], 32'hDEAD_BEEF);
      nxt();
    end

    // reset pulse with two reads in flight
    for (int t = 0; t <= 7; t++) begin
      rst = (t == 2);
      case (t)
        0:       drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
      endcase
      @(negedge clk);
      if (t == 2)
        for (int l = 1; l <= 3; l++) chk($sformatf("midrst stall L%0d", l), {31'd0, stall[l]}, 32'd1);
      for (int l = 1; l <= 3; l++)
        chk_rsp($sformatf("midrst t%0d", t), l, (t == 1) && (l == 1), 1'b0,
                ((t == 1) && (l == 1)) ? 32'hDEAD_BEEF : 32'h0);
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
